// File: rtl/inst_arb_pkg.sv
// Shared types and helpers for the instance round-robin arbiter.
// Provides the FSM state enum, default requester count and a one-hot decoder.
package inst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam int DEFAULT_NUM_REQ = 5;

    // Index of the set bit of a one-hot vector (up to 16 bits); 0 if none.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/inst_rr_pick.sv
// Rotating priority encoder: first set req bit scanning ptr, ptr+1, ...
// Ports: req, ptr in; pick_valid, pick_id out. Wrap is modulo NUM_REQ.
module inst_rr_pick
    import inst_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               pick_valid,
    output logic [ID_W-1:0]    pick_id
);

    localparam logic [ID_W:0] N = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0] sum;

    // Scan from the farthest offset down so the nearest hit wins last.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        sum        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= N) sum = sum - N;
            if (req[sum[ID_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_id    = sum[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/inst_rr_arbiter.sv
// Round-robin arbiter sharing one resource among sibling instances.
// Ports: clk, rst (async high), req, rel in; gnt, gnt_valid, gnt_id,
// busy, timeout out. Macro INST_ARB_HOLD_TIMEOUT_EN adds hold timeout.
module inst_rr_arbiter
    import inst_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEFAULT_NUM_REQ,
    parameter int ID_W     = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               timeout
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_e         state, state_n;
    logic [ID_W-1:0]    ptr, ptr_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [ID_W-1:0]    gnt_id_n;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic               rel_hit;
    logic               force_rel;
    logic               timeout_n;

    inst_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

`ifdef INST_ARB_HOLD_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
    logic              timeout_r;
    logic              hold_exp;

    assign hold_exp = (hold_cnt >= HOLD_W'(MAX_HOLD - 1));
    assign timeout  = timeout_r;
`else
    assign timeout  = 1'b0;
`endif

    // Either an explicit release or the holder dropping its request.
    assign rel_hit = rel[gnt_id] | ~req[gnt_id];

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        timeout_n = 1'b0;
        force_rel = 1'b0;
`ifdef INST_ARB_HOLD_TIMEOUT_EN
        hold_cnt_n = hold_cnt;
        force_rel  = hold_exp;
`endif
        unique case (state)
            IDLE, GAP: begin
                gnt_n = '0;
                if (pick_valid) begin
                    gnt_n    = ONE << pick_id;
                    gnt_id_n = pick_id;
                    state_n  = GRANT;
`ifdef INST_ARB_HOLD_TIMEOUT_EN
                    hold_cnt_n = '0;
`endif
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (rel_hit | force_rel) begin
                    gnt_n     = '0;
                    state_n   = GAP;
                    timeout_n = force_rel & ~rel_hit;
                    if (gnt_id == ID_W'(NUM_REQ - 1)) ptr_n = '0;
                    else                              ptr_n = gnt_id + 1'b1;
                end
`ifdef INST_ARB_HOLD_TIMEOUT_EN
                else if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
`endif
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
        end
    end

`ifdef INST_ARB_HOLD_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_n;
            timeout_r <= timeout_n;
        end
    end
`endif

    assign gnt_valid = |gnt;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_inst_rr_arbiter.sv
// Scoreboard bench for inst_rr_arbiter: stimulus pushes expected grants,
// a negedge monitor pops and compares each new grant it observes.
module tb_inst_rr_arbiter;
    import inst_arb_pkg::*;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] rel = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [2:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int id;
        int cyc;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] prev_gnt = '0;

    inst_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_gnt(input int id, input int at);
        exp_t e;
        e.id  = id;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // Monitor: invariants every cycle, scoreboard pop on each new grant.
    always @(negedge clk) begin
        if (rst) begin
            prev_gnt <= '0;
        end else begin
            chk("onehot", int'($onehot0(gnt)), 1);
            chk("gnt_valid", int'(gnt_valid), int'(|gnt));
`ifndef INST_ARB_HOLD_TIMEOUT_EN
            chk("timeout_off", int'(timeout), 0);
`endif
            if (gnt != '0 && gnt != prev_gnt) begin
                if (sb.size() == 0) begin
                    chk("unexpected_gnt", int'(gnt), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("gnt_id", int'(gnt_id), e.id);
                    chk("gnt_vec", int'(gnt), 1 << e.id);
                    chk("gnt_idx", int'(onehot_to_idx(16'(gnt))), e.id);
                    chk("gnt_cycle", cyc, e.cyc);
                end
            end
            prev_gnt <= gnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int f;
        int g;
        int order[6];
        order = '{0, 1, 2, 3, 4, 0};

        #1 rst = 1'b1;
        step(2);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(gnt_valid), 0);
        chk("rst_id", int'(gnt_id), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst = 1'b0;
        step(2);
        chk("idle_busy", int'(busy), 0);

        // Single requester from ptr 0
        c = cyc;
        req = 5'b00100;
        expect_gnt(2, c + 1);
        step(5);
        chk("single_held", int'(gnt), 5'b00100);
        rel = 5'b00100;
        step(1);
        rel = '0;
        req = '0;
        chk("single_gap", int'(gnt), 0);
        chk("single_gap_busy", int'(busy), 1);
        chk("single_gap_id", int'(gnt_id), 2);
        step(1);
        chk("single_idle", int'(busy), 0);

        // ptr=3 picks 3 over 0; req drop releases; wrap from ptr=4 to 0
        c = cyc;
        req = 5'b01001;
        expect_gnt(3, c + 1);
        step(3);
        req = 5'b00011;
        expect_gnt(0, c + 5);
        step(1);
        chk("drop_gap", int'(gnt), 0);
        step(3);
        rel = 5'b00001;
        expect_gnt(1, c + 9);
        step(1);
        rel = '0;
        req = 5'b00010;
        chk("relreq_gap", int'(gnt), 0);
        step(2);
        chk("gnt1_held", int'(gnt), 5'b00010);

        // Foreign release is ignored
        rel = 5'b01000;
        step(1);
        rel = '0;
        chk("foreign_gnt", int'(gnt), 5'b00010);
        chk("foreign_id", int'(gnt_id), 1);
        chk("foreign_busy", int'(busy), 1);
        req = '0;
        step(1);
        chk("drop1_gap", int'(gnt), 0);
        step(1);
        chk("drop1_idle", int'(busy), 0);

        // Async reset mid-grant
        c = cyc;
        req = 5'b00100;
        expect_gnt(2, c + 1);
        step(2);
        chk("pre_rst_id", int'(gnt_id), 2);
        #3 rst = 1'b1;
        #1;
        chk("arst_gnt", int'(gnt), 0);
        chk("arst_valid", int'(gnt_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_id", int'(gnt_id), 0);
        step(1);
        req = 5'b11111;
        step(1);
        rst = 1'b0;

        // All requesting: order 0,1,2,3,4,0 from a reset pointer
        f = cyc;
        for (int k = 0; k < 6; k++) begin
            expect_gnt(order[k], f + 1 + 5 * k);
        end
        for (int k = 0; k < 6; k++) begin
            g = f + 1 + 5 * k;
            step(g + 3 - cyc);
            chk("rr_held", int'(gnt), 1 << order[k]);
            rel = 5'(1 << order[k]);
            step(1);
            rel = '0;
            if (k == 5) req = '0;
            chk("rr_gap", int'(gnt), 0);
        end
        step(2);
        chk("rr_idle", int'(busy), 0);

        // Long hold of requester 0 (ptr=1 wraps to 0)
        c = cyc;
        req = 5'b00001;
        expect_gnt(0, c + 1);
`ifdef INST_ARB_HOLD_TIMEOUT_EN
        expect_gnt(0, c + 18);
        step(16);
        chk("hold_last", int'(gnt), 5'b00001);
        chk("hold_no_to", int'(timeout), 0);
        step(1);
        chk("to_gnt", int'(gnt), 0);
        chk("to_pulse", int'(timeout), 1);
        step(1);
        chk("to_clear", int'(timeout), 0);
        chk("to_regrant", int'(gnt), 5'b00001);
        req = '0;
`else
        step(20);
        chk("hold_forever", int'(gnt), 5'b00001);
        chk("hold_busy", int'(busy), 1);
        req = '0;
`endif
        step(3);
        chk("end_idle", int'(busy), 0);

        for (int w = 0; w < 50 && sb.size() != 0; w++) step(1);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("missing_gnt", -1, e.id);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
